// File: rtl/btn_event_gen_if.sv
// Button event bundle: debounced level in, one-cycle event pulses and held level out.
// Latency: none, this is wiring only.
// Backpressure: none; the level is sampled every cycle and the pulses cannot be stalled.
interface btn_event_gen_if;
  logic btn_clean;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  // Producer of the button level and consumer of the events.
  modport master (
    output btn_clean,
    input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

  // Event generator side.
  modport slave (
    input  btn_clean,
    output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press/release/click/long-press/auto-repeat pulses.
// Latency: every output is registered, so each event appears one cycle after the edge that samples its cause.
// Backpressure: none; the level is sampled every cycle and the pulses cannot be stalled.
module btn_event_gen #(
  parameter logic [23:0] LONG_LIMIT    = 24'd10_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input logic           clk,
  input logic           rst,
  btn_event_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  localparam logic [23:0] LONG_LAST   = LONG_LIMIT - 24'd1;
  localparam logic [23:0] REPEAT_LAST = REPEAT_PERIOD - 24'd1;

  state_t      state;
  logic [23:0] cnt;
  logic        btn_q;
  logic        rise;

  // A press is a rising edge relative to last cycle's level. Because btn_q
  // tracks the input through reset, a button already down at reset never
  // counts as a press.
  assign rise = bus.btn_clean & ~btn_q;

  // Press/hold FSM with registered pulse and held outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      btn_q             <= bus.btn_clean;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.click_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.held          <= 1'b0;
    end else begin
      btn_q             <= bus.btn_clean;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.click_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state           <= SHORT;
            cnt             <= '0;
            bus.press_pulse <= 1'b1;
            bus.held        <= 1'b1;
          end
        end
        SHORT: begin
          // Release is checked first so a release landing on the threshold
          // cycle is still reported as a click.
          if (!bus.btn_clean) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
            bus.click_pulse   <= 1'b1;
            bus.held          <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state          <= LONG;
            cnt            <= '0;
            bus.long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        LONG: begin
          if (!bus.btn_clean) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
          end else if (REPEAT_EN) begin
            if (cnt == REPEAT_LAST) begin
              cnt              <= '0;
              bus.repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen: one instance with auto-repeat, one without, same stimulus.
// Latency: outputs are checked on the falling edge after the rising edge that produced them.
// Backpressure: none; the button level is driven on falling edges.
module tb_btn_event_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  btn_event_gen_if bus0 ();
  btn_event_gen_if bus1 ();

  assign bus0.btn_clean = btn;
  assign bus1.btn_clean = btn;

  btn_event_gen #(.LONG_LIMIT(24'd8), .REPEAT_PERIOD(24'd4), .REPEAT_EN(1'b1)) u_dut_rep (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  btn_event_gen #(.LONG_LIMIT(24'd8), .REPEAT_PERIOD(24'd4), .REPEAT_EN(1'b0)) u_dut_norep (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  // Outputs packed as {press, release, click, long, repeat, held}.
  logic [5:0] o0, o1;
  assign o0 = {bus0.press_pulse, bus0.release_pulse, bus0.click_pulse,
               bus0.long_pulse, bus0.repeat_pulse, bus0.held};
  assign o1 = {bus1.press_pulse, bus1.release_pulse, bus1.click_pulse,
               bus1.long_pulse, bus1.repeat_pulse, bus1.held};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs k cycles after the press edge E0 for a hold that
  // releases at edge E<h>: long at E8 only if still held there, repeats
  // every 4 cycles after E8, click only if released by E8.
  function automatic logic [5:0] expv(int k, int h, bit en);
    logic p, r, c, l, rp, hd;
    p  = (k == 0);
    r  = (k == h);
    c  = (k == h) && (h <= 8);
    l  = (h > 8) && (k == 8);
    rp = en && (k > 8) && (k < h) && (((k - 8) % 4) == 0);
    hd = (k < h);
    return {p, r, c, l, rp, hd};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Press for h sampled edges (E0..E<h-1>), release at E<h>, check both DUTs each cycle.
  task automatic run_hold(input string tag, input int h);
    btn = 1'b1;
    for (int k = 0; k <= h + 1; k++) begin
      step();
      check($sformatf("%s_rep_k%0d", tag, k),   32'(o0), 32'(expv(k, h, 1'b1)));
      check($sformatf("%s_norep_k%0d", tag, k), 32'(o1), 32'(expv(k, h, 1'b0)));
      if (k == h - 1) btn = 1'b0;
    end
  endtask

  initial begin
    logic [5:0] prev [2];
    bit         want_press [2];
    logic [5:0] o;
    int         run_len;

    // Reset state with the button up.
    rst = 1'b1;
    btn = 1'b0;
    step();
    step();
    check("reset_rep",   32'(o0), 32'd0);
    check("reset_norep", 32'(o1), 32'd0);
    rst = 1'b0;
    step();
    check("idle_rep", 32'(o0), 32'd0);

    // Tap, boundary release at threshold, release just after threshold,
    // and long hold with repeats; the no-repeat DUT covers the 30-cycle hold.
    run_hold("tap", 3);
    run_hold("edge8", 8);
    run_hold("edge9", 9);
    run_hold("hold20", 21);
    run_hold("hold30", 31);

    // Button held across reset deassertion: no press until released and re-pressed.
    rst = 1'b1;
    btn = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("held_rst_rep_k%0d", k),   32'(o0), 32'd0);
      check($sformatf("held_rst_norep_k%0d", k), 32'(o1), 32'd0);
    end
    btn = 1'b0;
    step();
    step();
    check("rel_after_rst", 32'(o0), 32'd0);
    run_hold("press_after_rst", 3);

    // Reset while in LONG aborts with no release.
    btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("pre_abort_k%0d", k), 32'(o0), 32'(expv(k, 1000, 1'b1)));
    end
    rst = 1'b1;
    step();
    check("abort_rep",   32'(o0), 32'd0);
    check("abort_norep", 32'(o1), 32'd0);
    btn = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_abort_k%0d", k), 32'(o0 | o1), 32'd0);
    end

    // Random traffic: pulses one cycle wide, press/release alternate, click only with release.
    prev[0] = '0;
    prev[1] = '0;
    want_press[0] = 1'b1;
    want_press[1] = 1'b1;
    run_len = 0;
    for (int c = 0; c < 600; c++) begin
      if (run_len == 0) begin
        btn = 1'($urandom_range(0, 1));
        run_len = $urandom_range(1, 16);
      end
      run_len--;
      step();
      for (int d = 0; d < 2; d++) begin
        o = (d == 0) ? o0 : o1;
        check($sformatf("width_d%0d", d), 32'(prev[d][5:1] & o[5:1]), 32'd0);
        check($sformatf("alt_d%0d", d),
              32'({o[5] & ~want_press[d], o[4] & want_press[d]}), 32'd0);
        check($sformatf("click_rel_d%0d", d), 32'(o[3] & ~o[4]), 32'd0);
        if (o[5]) want_press[d] = 1'b0;
        if (o[4]) want_press[d] = 1'b1;
        prev[d] = o;
      end
    end
    btn = 1'b0;
    step();
    step();
    check("final_idle", 32'(o0 | o1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 Parameter LONG_LIMIT, default 24'd10_000_000, is the number of cycles held after press before the long-press event; legal range 2 to 2^24-1.
REQ-002 Parameter REPEAT_PERIOD, default 24'd2_500_000, is the number of cycles between auto-repeat events while in long-press; legal range 2 to 2^24-1.
REQ-003 Parameter REPEAT_EN, default 1, enables auto-repeat when 1; 0 disables repeat_pulse entirely.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_clean  input  1  debounced button level, synchronous to clk, 1 = pressed.
REQ-007 press_pulse  output  1  one-cycle pulse on press.
REQ-008 release_pulse  output  1  one-cycle pulse on any release.
REQ-009 click_pulse  output  1  one-cycle pulse on release before long-press threshold (tap).
REQ-010 long_pulse  output  1  one-cycle pulse when long-press threshold is reached.
REQ-011 repeat_pulse  output  1  one-cycle pulse per auto-repeat interval.
REQ-012 held  output  1  level, 1 while FSM is not IDLE.

Function
REQ-013 All outputs shall be registered; no combinational path from btn_clean to any output.
REQ-014 The block shall keep a 1-cycle history register btn_q; rise = btn_clean & ~btn_q, fall = ~btn_clean & btn_q.
REQ-015 FSM states shall be IDLE, SHORT, LONG; 24-bit counter cnt.
REQ-016 IDLE: on rise, go SHORT, cnt <= 0, press_pulse <= 1 (press_pulse high in the cycle after the edge sampling the rise).
REQ-017 SHORT, btn_clean=1: if cnt == LONG_LIMIT-1 then long_pulse <= 1, go LONG, cnt <= 0; else cnt <= cnt+1.
REQ-018 SHORT, btn_clean=0: go IDLE, release_pulse <= 1, click_pulse <= 1, cnt <= 0.
REQ-019 Simultaneous threshold and release in SHORT: release wins; click_pulse and release_pulse asserted, long_pulse not asserted.
REQ-020 LONG, btn_clean=1, REPEAT_EN=1: if cnt == REPEAT_PERIOD-1 then repeat_pulse <= 1, cnt <= 0; else cnt <= cnt+1.
REQ-021 LONG, btn_clean=1, REPEAT_EN=0: cnt holds at 0; no pulses.
REQ-022 LONG, btn_clean=0: go IDLE, release_pulse <= 1 only (no click_pulse, no repeat_pulse that cycle).
REQ-023 Pulse outputs shall default to 0 every cycle unless set by REQ-016..REQ-022; no pulse exceeds one cycle.
REQ-024 held shall be 1 exactly while state is SHORT or LONG (registered alongside state).
REQ-025 cnt shall never wrap; it is cleared at every threshold and state exit.

Reset
REQ-026 While rst=1: state <= IDLE, cnt <= 0, all outputs <= 0, btn_q <= btn_clean.
REQ-027 A button held across reset deassertion shall generate no press_pulse; a release then a new press is required.
REQ-028 rst asserted mid-press (SHORT or LONG) shall abort silently: no release_pulse or click_pulse is generated.

Verification (LONG_LIMIT=8, REPEAT_PERIOD=4, REPEAT_EN=1 unless stated)
REQ-029 Tap: btn_clean high 3 cycles then low -> press_pulse 1 cycle after rise; release_pulse and click_pulse together 1 cycle after fall; long_pulse never.
REQ-030 Hold 20 cycles: press edge E0 -> press_pulse after E0, long_pulse after E8, repeat_pulse after E12, E16, E20; release -> release_pulse only.
REQ-031 Boundary: release sampled at edge E8 (same edge as threshold) -> click_pulse and release_pulse, no long_pulse.
REQ-032 REPEAT_EN=0, hold 30 cycles -> exactly one long_pulse after E8, zero repeat_pulse, held=1 throughout, release_pulse on release.
REQ-033 Reset: btn_clean=1 during and after rst -> no press_pulse; then low 2 cycles and high -> normal press_pulse; rst in LONG -> all outputs 0 next cycle, no release_pulse.
REQ-034 Pulse checker: on random btn_clean traffic, every pulse is one cycle wide, and press_pulse and release_pulse alternate strictly between resets.
